// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, constants and helpers for the 7-segment scan driver
package seg7_pkg;

  typedef enum logic [0:0] {
    STARTUP_LT = 1'b0,
    RUN        = 1'b1
  } state_t;

  localparam int              BCD_W      = 4;
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;
  localparam int              MAX_DIGITS = 8;

  // Digit-enable pattern for a scan index (widest supported display)
  function automatic logic [MAX_DIGITS-1:0] onehot(input logic [2:0] idx);
    return MAX_DIGITS'(1) << idx;
  endfunction

endpackage

// File: rtl/seg7_lzb_mask.sv
// rtl/seg7_lzb_mask.sv - leading-zero blank mask from the display value
module seg7_lzb_mask
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic [BCD_W*NUM_DIGITS-1:0] disp,
  input  logic                        lzb_en,
  output logic [NUM_DIGITS-1:0]       blank_mask
);

  // Walk down from the most significant digit while every nibble so far is zero; digit 0 always shows
  always_comb begin : lzb_walk
    logic run_zero;
    run_zero   = lzb_en;
    blank_mask = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      run_zero      = run_zero && (disp[i*BCD_W +: BCD_W] == '0);
      blank_mask[i] = run_zero;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed scan controller feeding a 4511-style BCD decoder
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 16,
  parameter int LT_FRAMES  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BCD_W*NUM_DIGITS-1:0] bcd_in,
  input  logic                        load,
  input  logic                        lzb_en,
  input  logic                        lamp_test_req,
  output logic [BCD_W-1:0]            D,
  output logic                        LE,
  output logic                        BL,
  output logic                        LT,
  output logic [NUM_DIGITS-1:0]       dig_sel,
  output logic                        frame_start
);

  localparam int CYC_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int LTC_W = (LT_FRAMES > 1) ? $clog2(LT_FRAMES) : 1;
  localparam int VAL_W = BCD_W * NUM_DIGITS;

  logic [CYC_W-1:0]      cyc;
  logic [IDX_W-1:0]      idx;
  logic [LTC_W-1:0]      lt_cnt, lt_cnt_nxt;
  state_t                state, state_nxt;
  logic [VAL_W-1:0]      disp, disp_nxt, pend;
  logic                  pend_valid;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic                  slot_end, frame_bnd, frame_end, in_blank;
  logic [BCD_W-1:0]      d_nxt;
  logic                  le_nxt, bl_nxt, lt_nxt;
  logic [NUM_DIGITS-1:0] sel_nxt;

  assign slot_end  = (cyc == CYC_W'(SCAN_DIV - 1));
  assign frame_bnd = (cyc == '0) && (idx == '0);
  assign frame_end = slot_end && (idx == IDX_W'(NUM_DIGITS - 1));
  assign in_blank  = (cyc < CYC_W'(BLANK_CYC));

  // Slot cycle counter and digit index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cyc <= '0;
      idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      cyc <= cyc + CYC_W'(1);
    end
  end

  // Display value in force from this cycle on; it only changes on the frame boundary
  always_comb begin
    disp_nxt = disp;
    if (frame_bnd) begin
      if (load) begin
        disp_nxt = bcd_in;
      end else if (pend_valid) begin
        disp_nxt = pend;
      end
    end
  end

  // Display and pending value registers; a boundary load bypasses pending
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp       <= '0;
      pend       <= '0;
      pend_valid <= 1'b0;
    end else begin
      disp <= disp_nxt;
      if (frame_bnd) begin
        pend_valid <= 1'b0;
      end else if (load) begin
        pend       <= bcd_in;
        pend_valid <= 1'b1;
      end
    end
  end

  // Lamp-test state and completed-frame counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= STARTUP_LT;
      lt_cnt <= '0;
    end else begin
      state  <= state_nxt;
      lt_cnt <= lt_cnt_nxt;
    end
  end

  // Leave startup lamp test after the last lamp-test frame ends
  always_comb begin
    state_nxt  = state;
    lt_cnt_nxt = lt_cnt;
    case (state)
      STARTUP_LT: begin
        if (LT_FRAMES == 0) begin
          state_nxt = RUN;
        end else if (frame_end) begin
          if (int'(lt_cnt) >= LT_FRAMES - 1) begin
            state_nxt = RUN;
          end else begin
            lt_cnt_nxt = lt_cnt + LTC_W'(1);
          end
        end
      end
      RUN:     state_nxt = RUN;
      default: state_nxt = STARTUP_LT;
    endcase
  end

  seg7_lzb_mask #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_lzb_mask (
    .disp       (disp_nxt),
    .lzb_en     (lzb_en),
    .blank_mask (blank_mask)
  );

  // Decoder and digit-enable values for the current slot phase
  always_comb begin
    d_nxt   = disp_nxt[int'(idx)*BCD_W +: BCD_W];
    le_nxt  = !in_blank;
    bl_nxt  = !in_blank && !blank_mask[idx];
    sel_nxt = in_blank ? '0 : NUM_DIGITS'(onehot(3'(idx)));
    lt_nxt  = (state == RUN || LT_FRAMES == 0) ? !lamp_test_req : 1'b0;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      D           <= '0;
      LE          <= 1'b0;
      BL          <= 1'b0;
      LT          <= 1'b1;
      dig_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      D           <= d_nxt;
      LE          <= le_nxt;
      BL          <= bl_nxt;
      LT          <= lt_nxt;
      dig_sel     <= sel_nxt;
      frame_start <= frame_bnd;
    end
  end

endmodule
